// File: rtl/timer_ip.sv
// Memory-mapped 32-bit down-counting timer with one-shot and periodic modes.
// Register map: CTRL 0x00, LOAD 0x04, VALUE 0x08 (read-only), STATUS 0x0C (write-1-to-clear).
module timer_ip (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        timeout
);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_LOAD   = 8'h04;
  localparam logic [7:0] ADDR_VALUE  = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;

  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] loadVal_q, loadVal_d;
  logic [31:0] countVal_q, countVal_d;
  logic        status_q, status_d;
  logic        timeout_q, timeout_d;

  logic        wrCtrl, wrLoad, wrStatus, rdEn, expire;
  logic        unusedAddrHi;

  assign unusedAddrHi = ^addr[31:8];

  assign wrCtrl   = sel && we && (addr[7:0] == ADDR_CTRL);
  assign wrLoad   = sel && we && (addr[7:0] == ADDR_LOAD);
  assign wrStatus = sel && we && (addr[7:0] == ADDR_STATUS);
  assign rdEn     = sel && !we;

  // Expiry is the edge on which a running count sits at 1.
  assign expire = ctrl_q[0] && (countVal_q == 32'd1);

  always_comb begin
    ctrl_d     = ctrl_q;
    loadVal_d  = loadVal_q;
    countVal_d = countVal_q;
    status_d   = status_q;
    timeout_d  = timeout_q;

    // A CTRL write overrides any expiry on the same edge; enabling restarts from the old LOAD.
    if (wrCtrl) begin
      ctrl_d    = wdata[1:0];
      timeout_d = 1'b0;
      if (wdata[0]) begin
        countVal_d = loadVal_q;
      end
    end else begin
      if (ctrl_q[0]) begin
        if (countVal_q > 32'd1) begin
          countVal_d = countVal_q - 32'd1;
        end else if (expire) begin
          countVal_d = ctrl_q[1] ? loadVal_q : 32'd0;
        end
      end

      // Set beats a simultaneous STATUS clear; periodic timeout is a single-cycle pulse.
      if (expire) begin
        timeout_d = 1'b1;
        status_d  = 1'b1;
      end else begin
        if (ctrl_q[0] && ctrl_q[1]) begin
          timeout_d = 1'b0;
        end
        if (wrStatus && wdata[0]) begin
          status_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
    end

    if (wrLoad) begin
      loadVal_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q     <= 2'b00;
      loadVal_q  <= 32'd0;
      countVal_q <= 32'd0;
      status_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      loadVal_q  <= loadVal_d;
      countVal_q <= countVal_d;
      status_q   <= status_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rdEn) begin
      case (addr[7:0])
        ADDR_CTRL:   rdata = {30'd0, ctrl_q};
        ADDR_LOAD:   rdata = loadVal_q;
        ADDR_VALUE:  rdata = countVal_q;
        ADDR_STATUS: rdata = {31'd0, status_q};
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_timer_ip.sv
// Directed and randomized bench for timer_ip; the reference model tracks each run as
// (period latched at start/reload, edges elapsed) rather than a stored count.
module tb_timer_ip;

  logic        clk = 1'b0;
  logic        resetn, sel, we;
  logic [31:0] addr, wdata, rdata;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  bit          mEn, mMode, mStatus, mTimeout;
  int unsigned mLoad, mPeriod, mElapsed, mFrozen;

  always #5 clk = ~clk;

  timer_ip dut (
    .clk     (clk),
    .resetn  (resetn),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .timeout (timeout)
  );

  function automatic logic [31:0] modelValue();
    if (!mEn) return mFrozen;
    return mPeriod - mElapsed;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    case (a[7:0])
      8'h00:   return {30'd0, mMode, mEn};
      8'h04:   return mLoad;
      8'h08:   return modelValue();
      8'h0C:   return {31'd0, mStatus};
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelEdge(input logic r, input logic s, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    logic [31:0] oldLoad;
    bit          expire;
    v       = modelValue();
    oldLoad = mLoad;
    if (!r) begin
      mEn = 0; mMode = 0; mStatus = 0; mTimeout = 0;
      mLoad = 0; mPeriod = 0; mElapsed = 0; mFrozen = 0;
      return;
    end
    if (s && w && a[7:0] == 8'h00) begin
      mEn      = d[0];
      mMode    = d[1];
      mTimeout = 0;
      if (d[0]) begin
        mPeriod  = oldLoad;
        mElapsed = 0;
      end else begin
        mFrozen = v;
      end
    end else begin
      expire = mEn && (v == 32'd1);
      if (expire) begin
        mTimeout = 1;
        mStatus  = 1;
        if (mMode) begin
          mPeriod  = oldLoad;
          mElapsed = 0;
        end else begin
          mElapsed = mPeriod;
        end
      end else begin
        if (mEn && v > 32'd1) mElapsed++;
        if (mEn && mMode) mTimeout = 0;
        if (s && w && a[7:0] == 8'h0C && d[0]) begin
          mStatus  = 0;
          mTimeout = 0;
        end
      end
    end
    if (s && w && a[7:0] == 8'h04) mLoad = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output logic to);
    resetn = r; sel = s; we = w; addr = a; wdata = d;
    #1;
    rd = rdata;
    to = timeout;
    if (s && !w) checkOutput("rdata_model", rdata, modelRead(a));
    else         checkOutput("rdata_idle", rdata, 32'd0);
    checkOutput("timeout_model", {31'd0, timeout}, {31'd0, mTimeout});
    @(posedge clk);
    modelEdge(r, s, w, a, d);
    #1;
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        to;
    applyStimulus(1'b1, 1'b1, 1'b1, a, d, rd, to);
  endtask

  task automatic readReg(input logic [31:0] a, output logic [31:0] rd, output logic to);
    applyStimulus(1'b1, 1'b1, 1'b0, a, 32'd0, rd, to);
  endtask

  task automatic idleCycle();
    logic [31:0] rd;
    logic        to;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd, to);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic        to, r, s, w;

    resetn = 1'b0; sel = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(posedge clk);
    modelEdge(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;

    readReg(32'h00, rd, to); checkOutput("rst_ctrl", rd, 32'd0);
    readReg(32'h04, rd, to); checkOutput("rst_load", rd, 32'd0);
    readReg(32'h08, rd, to); checkOutput("rst_value", rd, 32'd0);
    readReg(32'h0C, rd, to); checkOutput("rst_status", rd, 32'd0);
    checkOutput("rst_timeout", {31'd0, to}, 32'd0);

    // One-shot count from 10 down to a sticky expiry.
    writeReg(32'h04, 32'd10);
    writeReg(32'h00, 32'h1);
    for (int i = 0; i <= 10; i++) begin
      readReg(32'h08, rd, to);
      checkOutput("os_value", rd, 32'(10 - i));
      checkOutput("os_timeout", {31'd0, to}, {31'd0, (i == 10)});
    end
    repeat (3) idleCycle();
    readReg(32'h0C, rd, to);
    checkOutput("os_status", rd, 32'd1);
    checkOutput("os_sticky", {31'd0, to}, 32'd1);
    writeReg(32'h0C, 32'h1);
    readReg(32'h0C, rd, to);
    checkOutput("w1c_status", rd, 32'd0);
    checkOutput("w1c_timeout", {31'd0, to}, 32'd0);

    // Periodic with period 5.
    writeReg(32'h04, 32'd5);
    writeReg(32'h00, 32'h3);
    for (int i = 0; i < 12; i++) begin
      readReg(32'h08, rd, to);
      checkOutput("per_value", rd, 32'(5 - (i % 5)));
      checkOutput("per_timeout", {31'd0, to}, {31'd0, (i > 0 && i % 5 == 0)});
    end
    readReg(32'h0C, rd, to);
    checkOutput("per_status", rd, 32'd1);

    // Disable freezes the count; re-enable restarts from LOAD.
    writeReg(32'h04, 32'd6);
    writeReg(32'h00, 32'h1);
    for (int i = 0; i < 3; i++) begin
      readReg(32'h08, rd, to);
      checkOutput("dis_pre", rd, 32'(6 - i));
    end
    writeReg(32'h00, 32'h0);
    for (int i = 0; i < 6; i++) begin
      readReg(32'h08, rd, to);
      checkOutput("dis_hold", rd, 32'd3);
      checkOutput("dis_timeout", {31'd0, to}, 32'd0);
    end
    writeReg(32'h00, 32'h1);
    readReg(32'h08, rd, to);
    checkOutput("dis_reload", rd, 32'd6);

    // LOAD=0 never expires; LOAD=1 expires one edge after enabling.
    writeReg(32'h04, 32'd0);
    writeReg(32'h00, 32'h1);
    for (int i = 0; i < 20; i++) begin
      readReg(32'h08, rd, to);
      checkOutput("zero_value", rd, 32'd0);
      checkOutput("zero_timeout", {31'd0, to}, 32'd0);
    end
    writeReg(32'h04, 32'd1);
    writeReg(32'h00, 32'h1);
    readReg(32'h08, rd, to);
    checkOutput("one_value", rd, 32'd1);
    checkOutput("one_timeout0", {31'd0, to}, 32'd0);
    readReg(32'h08, rd, to);
    checkOutput("one_value_end", rd, 32'd0);
    checkOutput("one_timeout1", {31'd0, to}, 32'd1);

    // CTRL write on the expiry edge wins; STATUS clear on the expiry edge loses.
    writeReg(32'h0C, 32'h1);
    writeReg(32'h04, 32'd3);
    writeReg(32'h00, 32'h1);
    idleCycle();
    idleCycle();
    writeReg(32'h00, 32'h1);
    readReg(32'h08, rd, to);
    checkOutput("prio_value", rd, 32'd3);
    checkOutput("prio_timeout", {31'd0, to}, 32'd0);
    idleCycle();
    writeReg(32'h0C, 32'h1);
    readReg(32'h0C, rd, to);
    checkOutput("clr_lose_status", rd, 32'd1);
    checkOutput("clr_lose_timeout", {31'd0, to}, 32'd1);

    // Reset mid-count at VALUE=7.
    writeReg(32'h04, 32'd9);
    writeReg(32'h00, 32'h1);
    idleCycle();
    idleCycle();
    readReg(32'h08, rd, to);
    checkOutput("mid_value", rd, 32'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rd, to);
    readReg(32'h00, rd, to); checkOutput("mid_rst_ctrl", rd, 32'd0);
    readReg(32'h04, rd, to); checkOutput("mid_rst_load", rd, 32'd0);
    readReg(32'h0C, rd, to); checkOutput("mid_rst_status", rd, 32'd0);
    checkOutput("mid_rst_timeout", {31'd0, to}, 32'd0);
    repeat (5) idleCycle();
    readReg(32'h08, rd, to); checkOutput("mid_rst_value", rd, 32'd0);

    // Random traffic against the model, biased toward short LOAD values.
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 63) != 0);
      s = r ? 1'($urandom_range(0, 1)) : 1'b0;
      w = 1'($urandom_range(0, 1));
      a = $urandom & 32'hFFFF_FF00;
      case ($urandom_range(0, 5))
        0:       a[7:0] = 8'h00;
        1:       a[7:0] = 8'h04;
        2:       a[7:0] = 8'h08;
        3:       a[7:0] = 8'h0C;
        4:       a[7:0] = 8'h10;
        default: a[7:0] = 8'($urandom);
      endcase
      d = $urandom;
      if (a[7:0] == 8'h04 && $urandom_range(0, 3) != 0) d = $urandom_range(0, 12);
      applyStimulus(r, s, w, a, d, rd, to);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
